// File: rtl/call_ack_ctrl_pkg.sv
// call_ack_ctrl_pkg: shared lift encodings for floors, direction, lamp bits and door state
package call_ack_ctrl_pkg;
  localparam logic [1:0] F1 = 2'd0, F2 = 2'd1, F3 = 2'd2, F4 = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} dir_e;
  localparam logic [2:0] U1 = 3'd0, U2 = 3'd1, U3 = 3'd2, D2 = 3'd3, D3 = 3'd4, D4 = 3'd5;
  typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} door_e;
  // Lamp bit a service event at floor f would clear, given direction and calls pending there
  function automatic logic [2:0] svc_bit(logic [1:0] f, dir_e d, logic [5:0] pend);
    logic [2:0] up, dn;
    up = (f == F2) ? U2 : U3;
    dn = (f == F2) ? D2 : D3;
    if (f == F1) return U1;
    if (f == F4) return D4;
    return (d == DOWN) ? (pend[dn] ? dn : up) : (pend[up] ? up : dn);
  endfunction
endpackage

// File: rtl/call_ack_ctrl_door_dwell_timer.sv
// door_dwell_timer: door-open dwell counter with reload and forced close
module door_dwell_timer
  import call_ack_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic force_close,
  output logic door_open
);
  door_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic door_open_q, door_open_d;
  // Next state: open on load, reload while open, close after DWELL idle cycles or on floor change
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLOSED) begin
      if (load) begin
        state_d = OPEN;
        cnt_d = CW'(DWELL);
      end
    end else if (force_close) begin
      state_d = CLOSED;
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CW'(DWELL);
    end else if (cnt_q == CW'(1)) begin
      state_d = CLOSED;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    door_open_d = state_d == OPEN;
  end
  // Door state, counter and registered open flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      cnt_q <= '0;
      door_open_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      door_open_q <= door_open_d;
    end
  end
  assign door_open = door_open_q;
endmodule

// File: rtl/call_ack_ctrl.sv
// call_ack_ctrl: hall-call lamps, travel direction and door dwell on the lift side
module call_ack_ctrl
  import call_ack_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       u1,
  input  logic       u2,
  input  logic       u3,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  input  logic [1:0] floor,
  input  logic       done,
  output logic [5:0] lamp,
  output logic [1:0] dir,
  output logic       door_open
);
  logic [5:0] btn, btn_q, btn_d, edg, pend, clr, absorb_m, lamp_q, lamp_d;
  logic [1:0] prev_floor_q, prev_floor_d;
  logic [2:0] sel;
  logic absorb;
  dir_e dir_q, dir_d;
  assign btn = {d4, d3, d2, u3, u2, u1};
  // Press edges, service/absorb selection, lamp and direction next state
  always_comb begin
    edg = btn & ~btn_q;
    pend = lamp_q | edg;
    sel = svc_bit(floor, dir_q, pend);
    absorb = door_open && edg[sel];
    clr = done ? 6'b1 << sel : '0;
    absorb_m = absorb ? 6'b1 << sel : '0;
    lamp_d = pend & ~clr & ~absorb_m;
    dir_d = (done && lamp_d == '0) ? IDLE : (floor > prev_floor_q) ? UP : (floor < prev_floor_q) ? DOWN : dir_q;
    btn_d = btn;
    prev_floor_d = floor;
  end
  // Lamp, direction and edge-detect registers; prev floor tracks floor even in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q <= '0;
      dir_q <= IDLE;
      btn_q <= '0;
      prev_floor_q <= floor;
    end else begin
      lamp_q <= lamp_d;
      dir_q <= dir_d;
      btn_q <= btn_d;
      prev_floor_q <= prev_floor_d;
    end
  end
  door_dwell_timer #(.DWELL(DWELL), .CW(CW)) u_door (
    .clk(clk),
    .rst(rst),
    .load(done || absorb),
    .force_close(floor != prev_floor_q),
    .door_open(door_open)
  );
  // The lift must not move while the door is open
  always_ff @(posedge clk) begin
    if (!rst && door_open) assert (floor == prev_floor_q);
  end
  assign lamp = lamp_q;
  assign dir = dir_q;
endmodule

// File: doc/call_ack_ctrl.md
Name: call_ack_ctrl

Overview:
Hall-call acknowledge and door block on the lift side of the button interface. It works in the direction opposite to the request-queue path. It lights a lamp per hall call when pressed, and extinguishes it when the lift reports service at that floor. It tracks travel direction from the lift's floor code and runs the door-open dwell timer. It sits beside the input buffer and the lift FSM, observing the same raw buttons plus the FSM's floor/done outputs.

Parameters:
DWELL, 4, door-open cycles after a service event (legal range 1..255)
CW, 8, dwell counter width (must hold DWELL)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
u1  input  1  floor-1 up call, level from panel
u2  input  1  floor-2 up call
u3  input  1  floor-3 up call
d2  input  1  floor-2 down call
d3  input  1  floor-3 down call
d4  input  1  floor-4 down call
floor  input  2  current floor from lift FSM (0=F1 .. 3=F4)
done  input  1  one-cycle pulse: lift has served current floor
lamp  output  6  call lamps {d4,d3,d2,u3,u2,u1} (bit0=u1 .. bit5=d4)
dir  output  2  travel direction: 00 IDLE, 01 UP, 10 DOWN (11 never driven)
door_open  output  1  door state

Behaviour:
- Reset (synchronous, active-high): lamp=0, dir=IDLE, door_open=0, dwell counter=0, press-edge registers=0.
- Reset: prev_floor loads floor, so no spurious direction change is seen after reset.
- Reset mid-operation discards all lamps and the door state immediately.
- Press detect: rising edge per button input (registered previous level). The lamp bit sets on the cycle after the edge (1-cycle latency). A held button does not re-trigger.
- Direction, updated every cycle:
  - floor>prev_floor -> UP; floor<prev_floor -> DOWN; equal -> hold.
  - On done with no lamp left lit after this cycle's clear -> IDLE.
  - prev_floor <= floor every cycle.
- Service clear on done, selecting one bit at the current floor:
  - F1: clear u1. F4: clear d4.
  - F2/F3: if dir=UP or IDLE, clear the up call when lit, else the down call.
  - F2/F3: if dir=DOWN, clear the down call when lit, else the up call.
  - Only one bit is cleared per done.
  - done with no lit call at the floor clears nothing but still opens the door.
- Simultaneous press edge and clear on the same bit: clear wins (lamp stays 0).
- Press at the current floor while door_open=1, matching the bit that rule would clear: absorbed (lamp stays 0) and the dwell counter is reloaded.
- Door FSM, two states:
  - CLOSED: on done -> OPEN, counter<=DWELL, door_open=1 from the next cycle.
  - OPEN: counter decrements each cycle; done or an absorbed press reloads DWELL. When the counter reaches 1 and no reload occurs -> CLOSED.
  - door_open is high for exactly DWELL cycles after the last reload.
- Floor change while OPEN: forced to CLOSED, counter=0. This is a protocol violation, flagged by a simulation assertion only.
- Unused floor/button combinations (up at F4, down at F1) do not exist; no storage for them.

Decomposition:
- Shared lift package holds:
  - floor codes F1..F4
  - dir encodings IDLE/UP/DOWN
  - lamp bit index constants (U1=0, U2=1, U3=2, D2=3, D3=4, D4=5)
  - door state enum
- One natural sub-module: door_dwell_timer (load/decrement counter plus open flag). The lamp/direction logic stays in the top.

Test Plan:
- Assert rst 2 cycles with floor=2 -> lamp=000000, dir=00, door_open=0; hold floor=2 for 3 cycles -> dir stays 00.
- Pulse u2 1 cycle at idle -> lamp=000010 on next cycle. Hold u2 high 5 cycles -> no re-trigger, still 000010.
- lamp=001010 (u2,d2), floor steps 0->1, so dir=01; pulse done -> lamp=001000. door_open=1 for exactly 4 cycles, then 0.
- Same setup with dir=10: done at F2 clears d2 -> lamp=000010. A second done clears u2 -> lamp=0, dir=00.
- Door open at F3 after up-service; pulse u3 -> lamp stays 0, door_open extended to 4 cycles after the press. Press edge and done on the same cycle for that bit -> lamp stays 0.
- Lamps set and door open, assert rst 1 cycle -> next cycle lamp=0, door_open=0, dir=00.
